// File: rtl/gray_sweep_ctrl.sv
// Sweep sequencer for an external WIDTH-bit gray up/down counter: load LO, count to HI, optionally ping-pong.
// Optional build macro GRAY_SWEEP_CHECK_EN adds a step-tracking check of the counter's Q feedback.
module gray_sweep_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             CS,
  input  logic             START,
  input  logic             ABORT,
  input  logic             STALL,
  input  logic             MODE,
  input  logic [3:0]       LOOPS,
  input  logic [WIDTH-1:0] LO,
  input  logic [WIDTH-1:0] HI,
  input  logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] CNT_D,
  output logic             CNT_LD,
  output logic             CNT_EN,
  output logic             CNT_DNUP,
  output logic             CNT_CS,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR,
  output logic             ABORTED,
  output logic [2:0]       DBG_STATE
);

  // Handshake: START is a level sampled only in IDLE; the sweep ends with exactly one
  // of DONE, ABORTED or ERR pulsed for one cycle, after which the block is back in IDLE.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RUN_UP = 3'd2,
    S_RUN_DN = 3'd3,
    S_DONE   = 3'd4,
    S_CLR    = 3'd5
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] lo_l;
  logic [WIDTH-1:0] hi_l;
  logic             mode_l;
  logic [3:0]       loops_l;
  logic [3:0]       loop_cnt;
  logic             err_q;
  logic             fault_q;

  logic [WIDTH-1:0] qb;
  logic [WIDTH-1:0] tgt;
  logic             run;
  logic             at_tgt;
  logic             en_int;
  logic             fault;
  logic [3:0]       loop_next;

  function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  assign qb        = g2b(Q);
  assign tgt       = (state == S_RUN_DN) ? lo_l : hi_l;
  assign run       = (state == S_RUN_UP) || (state == S_RUN_DN);
  assign at_tgt    = (qb == tgt);
  assign en_int    = run && !STALL && !at_tgt;
  assign loop_next = loop_cnt + 4'd1;

`ifdef GRAY_SWEEP_CHECK_EN
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  logic [WIDTH-1:0] exp_q;
  logic [WIDTH-1:0] exp_bin_nxt;

  assign exp_bin_nxt = (state == S_RUN_DN) ? g2b(exp_q) - ONE : g2b(exp_q) + ONE;
  assign fault       = run && (Q != exp_q);

  // Mirrors every load/step this block commands, so Q can be checked against it.
  always_ff @(posedge CLK) begin
    if (CS) begin
      exp_q <= '0;
    end else if (state == S_LOAD) begin
      exp_q <= lo_l ^ (lo_l >> 1);
    end else if (en_int) begin
      exp_q <= exp_bin_nxt ^ (exp_bin_nxt >> 1);
    end
  end
`else
  assign fault = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (CS) begin
      state    <= S_IDLE;
      lo_l     <= '0;
      hi_l     <= '0;
      mode_l   <= 1'b0;
      loops_l  <= 4'd0;
      loop_cnt <= 4'd0;
      err_q    <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      err_q   <= 1'b0;
      fault_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ABORT) begin
            state <= S_CLR;
          end else if (START) begin
            if (LO <= HI) begin
              lo_l     <= LO;
              hi_l     <= HI;
              mode_l   <= MODE;
              loops_l  <= LOOPS;
              loop_cnt <= 4'd0;
              state    <= S_LOAD;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_LOAD: state <= ABORT ? S_CLR : S_RUN_UP;
        S_RUN_UP: begin
          if (fault) begin
            err_q   <= 1'b1;
            fault_q <= 1'b1;
            state   <= S_CLR;
          end else if (ABORT) begin
            state <= S_CLR;
          end else if (!STALL && at_tgt) begin
            state <= mode_l ? S_RUN_DN : S_DONE;
          end
        end
        S_RUN_DN: begin
          if (fault) begin
            err_q   <= 1'b1;
            fault_q <= 1'b1;
            state   <= S_CLR;
          end else if (ABORT) begin
            state <= S_CLR;
          end else if (!STALL && at_tgt) begin
            // Loop count wraps mod 16; with LOOPS == 0 the sweep never finishes on its own.
            loop_cnt <= loop_next;
            if ((loops_l != 4'd0) && (loop_next == loops_l)) state <= S_DONE;
            else                                              state <= S_RUN_UP;
          end
        end
        S_DONE:  state <= S_IDLE;
        S_CLR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // CS forces every output quiet except the counter clear, even in the cycle it first rises.
  always_comb begin
    CNT_D     = '0;
    CNT_LD    = 1'b0;
    CNT_EN    = 1'b0;
    CNT_DNUP  = 1'b0;
    BUSY      = 1'b0;
    DONE      = 1'b0;
    ERR       = 1'b0;
    ABORTED   = 1'b0;
    DBG_STATE = state;
    CNT_CS    = CS || (state == S_CLR);
    if (!CS) begin
      CNT_D    = lo_l ^ (lo_l >> 1);
      CNT_LD   = (state == S_LOAD);
      CNT_EN   = en_int;
      CNT_DNUP = (state == S_RUN_DN);
      BUSY     = (state == S_LOAD) || run || (state == S_CLR);
      DONE     = (state == S_DONE);
      ERR      = err_q;
      ABORTED  = (state == S_CLR) && !fault_q;
    end
  end

endmodule

// File: tb/tb_gray_sweep_ctrl.sv
// Directed bench for gray_sweep_ctrl; a behavioural gray counter closes the Q feedback loop.
module tb_gray_sweep_ctrl;
  localparam int W = 4;

  logic         CLK = 1'b0;
  logic         CS, START, ABORT, STALL, MODE;
  logic [3:0]   LOOPS;
  logic [W-1:0] LO, HI, Q;
  logic [W-1:0] CNT_D;
  logic         CNT_LD, CNT_EN, CNT_DNUP, CNT_CS, BUSY, DONE, ERR, ABORTED;
  logic [2:0]   DBG_STATE;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;

  always #5 CLK = ~CLK;

  gray_sweep_ctrl #(.WIDTH(W)) dut (
    .CLK(CLK), .CS(CS), .START(START), .ABORT(ABORT), .STALL(STALL), .MODE(MODE),
    .LOOPS(LOOPS), .LO(LO), .HI(HI), .Q(Q), .CNT_D(CNT_D), .CNT_LD(CNT_LD),
    .CNT_EN(CNT_EN), .CNT_DNUP(CNT_DNUP), .CNT_CS(CNT_CS), .BUSY(BUSY), .DONE(DONE),
    .ERR(ERR), .ABORTED(ABORTED), .DBG_STATE(DBG_STATE)
  );

  // Counter macro model: clear > load > count.
  logic [W-1:0] bin_q;
  logic         q_force_en = 1'b0;
  logic [W-1:0] q_force_val = '0;

  function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  assign Q = q_force_en ? q_force_val : (bin_q ^ (bin_q >> 1));

  always_ff @(posedge CLK) begin
    if (CNT_CS)      bin_q <= '0;
    else if (CNT_LD) bin_q <= g2b(CNT_D);
    else if (CNT_EN) bin_q <= CNT_DNUP ? bin_q - 4'd1 : bin_q + 4'd1;
  end

  always @(posedge CLK) if (DONE) done_cnt++;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Runs until DONE is seen; returns EN-cycle count and whether DONE arrived in budget.
  task automatic run_to_done(input int budget, output int en_cnt, output bit ok);
    en_cnt = 0;
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (DONE) begin
        ok = 1'b1;
        break;
      end
      if (CNT_EN) en_cnt++;
      step();
    end
  endtask

  task automatic start_sweep(input logic [W-1:0] lo_v, input logic [W-1:0] hi_v,
                             input logic mode_v, input logic [3:0] loops_v);
    LO = lo_v; HI = hi_v; MODE = mode_v; LOOPS = loops_v; START = 1'b1;
    step();
    START = 1'b0;
  endtask

  initial begin
    int  en_cnt;
    int  toggles;
    int  done_before;
    bit  ok;
    logic prev_dnup;

    CS = 1'b1; START = 1'b0; ABORT = 1'b0; STALL = 1'b0; MODE = 1'b0;
    LOOPS = 4'd0; LO = '0; HI = '0;
    step(); step();

    // Reset state
    check("rst_cnt_cs", 32'(CNT_CS), 32'd1);
    check("rst_busy",   32'(BUSY),   32'd0);
    check("rst_en",     32'(CNT_EN), 32'd0);
    check("rst_ld",     32'(CNT_LD), 32'd0);
    check("rst_d",      32'(CNT_D),  32'd0);
    check("rst_state",  32'(DBG_STATE), 32'd0);
    CS = 1'b0;
    #1;
    check("rst_release_cs", 32'(CNT_CS), 32'd0);

    // Scenario 1: one-shot 3..9
    start_sweep(4'd3, 4'd9, 1'b0, 4'd0);
    check("s1_ld",   32'(CNT_LD), 32'd1);
    check("s1_d",    32'(CNT_D),  32'b0010);
    check("s1_busy", 32'(BUSY),   32'd1);
    for (int c = 2; c <= 8; c++) begin
      step();
      check($sformatf("s1_en_c%0d", c), 32'(CNT_EN), 32'((c <= 7) ? 1 : 0));
    end
    check("s1_q_end", 32'(Q), 32'b1101);
    step();
    check("s1_done", 32'(DONE), 32'd1);
    check("s1_done_busy", 32'(BUSY), 32'd0);
    step();
    check("s1_done_pulse", 32'(DONE), 32'd0);

    // Scenario 3: same sweep, STALL for 3 cycles at Q=0111
    start_sweep(4'd3, 4'd9, 1'b0, 4'd0);
    for (int c = 2; c <= 11; c++) begin
      step();
      STALL = (c >= 4 && c <= 6);
      #1;
      check($sformatf("s3_en_c%0d", c), 32'(CNT_EN),
            32'(((c <= 3) || (c >= 7 && c <= 10)) ? 1 : 0));
      check($sformatf("s3_done_c%0d", c), 32'(DONE), 32'd0);
      if (c >= 4 && c <= 6) check($sformatf("s3_q_hold_c%0d", c), 32'(Q), 32'b0111);
    end
    STALL = 1'b0;
    step();
    check("s3_done_c12", 32'(DONE), 32'd1);
    step();

    // Scenario 2: ping-pong 0..15, two round trips; bounds changed mid-sweep
    start_sweep(4'd0, 4'd15, 1'b1, 4'd2);
    LO = 4'd5; HI = 4'd7;
    toggles = 0; en_cnt = 0; ok = 1'b0;
    prev_dnup = CNT_DNUP;
    for (int c = 0; c < 200; c++) begin
      step();
      if (DONE) begin
        ok = 1'b1;
        break;
      end
      if (CNT_DNUP != prev_dnup) begin
        toggles++;
        check($sformatf("s2_tgl%0d_q", toggles), 32'(Q), CNT_DNUP ? 32'b1000 : 32'b0000);
      end
      prev_dnup = CNT_DNUP;
      if (CNT_EN) en_cnt++;
    end
    check("s2_done_seen", 32'(ok), 32'd1);
    check("s2_en_total", 32'(en_cnt), 32'd60);
    check("s2_toggles",  32'(toggles), 32'd3);
    check("s2_q_at_done", 32'(Q), 32'b0000);
    step();

    // LO == HI one-shot: DONE with zero EN cycles
    start_sweep(4'd6, 4'd6, 1'b0, 4'd0);
    step();
    check("eq_en", 32'(CNT_EN), 32'd0);
    step();
    check("eq_done", 32'(DONE), 32'd1);
    step();

    // Scenario 4: infinite ping-pong, ABORT at Q=0101 going down
    done_before = done_cnt;
    start_sweep(4'd0, 4'd15, 1'b1, 4'd0);
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      step();
      if (CNT_DNUP && Q == 4'b0101) begin
        ok = 1'b1;
        break;
      end
    end
    check("s4_reach_0101", 32'(ok), 32'd1);
    ABORT = 1'b1;
    step();
    ABORT = 1'b0;
    #1;
    check("s4_cnt_cs",  32'(CNT_CS),  32'd1);
    check("s4_aborted", 32'(ABORTED), 32'd1);
    check("s4_clr_en",  32'(CNT_EN),  32'd0);
    step();
    check("s4_idle_busy", 32'(BUSY),    32'd0);
    check("s4_idle_abrt", 32'(ABORTED), 32'd0);
    check("s4_idle_q",    32'(Q),       32'd0);
    check("s4_no_done",   32'(done_cnt - done_before), 32'd0);

    // Scenario 5: LO > HI rejected
    start_sweep(4'd10, 4'd5, 1'b0, 4'd0);
    #1;
    check("s5_err",  32'(ERR),    32'd1);
    check("s5_ld",   32'(CNT_LD), 32'd0);
    check("s5_busy", 32'(BUSY),   32'd0);
    step();
    check("s5_err_pulse", 32'(ERR),  32'd0);
    check("s5_idle",      32'(DBG_STATE), 32'd0);

    // Scenario 6: CS mid RUN_UP, then a fresh sweep 2..4
    start_sweep(4'd3, 4'd9, 1'b0, 4'd0);
    step(); step(); step();
    CS = 1'b1;
    #1;
    check("s6_cs_cnt_cs", 32'(CNT_CS), 32'd1);
    check("s6_cs_en",     32'(CNT_EN), 32'd0);
    check("s6_cs_busy",   32'(BUSY),   32'd0);
    step();
    CS = 1'b0;
    #1;
    check("s6_state", 32'(DBG_STATE), 32'd0);
    check("s6_busy",  32'(BUSY),   32'd0);
    check("s6_cnt_cs", 32'(CNT_CS), 32'd0);
    check("s6_d",     32'(CNT_D),  32'd0);
    check("s6_q",     32'(Q),      32'd0);
    start_sweep(4'd2, 4'd4, 1'b0, 4'd0);
    run_to_done(50, en_cnt, ok);
    check("s6_restart_done", 32'(ok), 32'd1);
    check("s6_restart_en",   32'(en_cnt), 32'd2);
    step();

`ifdef GRAY_SWEEP_CHECK_EN
    // Q fault mid-run: ERR and counter clear, no ABORTED
    start_sweep(4'd3, 4'd9, 1'b0, 4'd0);
    step(); step();
    q_force_val = 4'b1111;
    q_force_en  = 1'b1;
    step();
    q_force_en = 1'b0;
    #1;
    check("chk_err",     32'(ERR),     32'd1);
    check("chk_cnt_cs",  32'(CNT_CS),  32'd1);
    check("chk_aborted", 32'(ABORTED), 32'd0);
    step();
    check("chk_idle", 32'(BUSY), 32'd0);
    check("chk_err_pulse", 32'(ERR), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
